sdr_modport: RTL and testbench

Passive SDRAM command-bus protocol checker with data-pin tristate, placed between the SDRAM controller core and the SDRAM device pins. It decodes every command on the bus and tracks a state machine for each of the four banks. It flags commands that are illegal for the target bank's state, and flags tRAS/tRCD timing violations. It also drives the bidirectional DQ bus from the controller's output data and enables, and returns the pin value as input data.

---
 rtl/sdr_modport.sv | 181 ++++++++++++++++++
 tb/tb_sdr_modport.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_modport.sv
// Passive SDRAM command-bus checker: per-bank state tracking, illegal-command and
// tRAS/tRCD flags, plus the DQ tristate between controller core and device pins.
module sdr_modport #(
   parameter int SDR_DW       = 16,
   parameter int SDR_BW       = 2,
   parameter int BURST_LENGTH = 1,
   parameter int TRAS         = 1,
   parameter int TCAS         = 1,
   parameter int TRCD         = 1,
   parameter int TRP          = 1
) (
   input  logic              sdram_clk,
   input  logic              sdram_reset,
   input  logic              sdr_init_done,
   input  logic              sdr_cs_n,
   input  logic              sdr_ras_n,
   input  logic              sdr_cas_n,
   input  logic              sdr_we_n,
   input  logic [1:0]        sdr_ba,
   input  logic [12:0]       sdr_addr,
   input  logic [SDR_DW-1:0] sdr_dout,
   input  logic [SDR_BW-1:0] sdr_den_n,
   inout  wire  [SDR_DW-1:0] sdr_dq,
   output logic [SDR_DW-1:0] sdr_din,
   output logic [15:0]       bank_state,
   output logic [3:0]        cmd_err,
   output logic [3:0]        tras_err,
   output logic [3:0]        trcd_err
);

   localparam logic [3:0] S_INIT = 4'd0;
   localparam logic [3:0] S_IDLE = 4'd1;
   localparam logic [3:0] S_REF  = 4'd2;
   localparam logic [3:0] S_ACTG = 4'd3;
   localparam logic [3:0] S_ACT  = 4'd4;
   localparam logic [3:0] S_RD   = 4'd5;
   localparam logic [3:0] S_RDPC = 4'd6;
   localparam logic [3:0] S_WR   = 4'd7;
   localparam logic [3:0] S_WRPC = 4'd8;
   localparam logic [3:0] S_PRE  = 4'd9;

   localparam logic [7:0] TRCD_M1 = 8'(TRCD - 1);
   localparam logic [7:0] TRAS_M1 = 8'(TRAS - 1);
   localparam logic [7:0] TRP_M1  = 8'(TRP - 1);
   localparam logic [7:0] BL_M1   = 8'(BURST_LENGTH - 1);

   // CAS latency does not influence any check; address bits other than A10 are ignored.
   localparam int unused_tcas = TCAS;
   wire unused_addr = ^{sdr_addr[12:11], sdr_addr[9:0]};

   assign sdr_dq  = (&sdr_den_n) ? {SDR_DW{1'bz}} : sdr_dout;
   assign sdr_din = sdr_dq;

   logic [3:0]       cmd;
   logic             is_lmr, is_ref, is_pre, is_act, is_wr, is_rd, is_bst;
   logic             a10, init_ok;
   logic [3:0]       act_t, rd_t, wr_t, pre_t, ref_t, lmr_t, bst_t, any_t;
   logic [3:0][3:0]  state_q, state_d;
   logic [3:0][7:0]  cnt_q, cnt_d;
   logic [3:0][7:0]  since_q, since_d;
   logic [3:0]       cmd_err_q, cmd_err_d;
   logic [3:0]       tras_err_q, tras_err_d;
   logic [3:0]       trcd_err_q, trcd_err_d;

   assign cmd = {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n};

   // Case-equality keeps X/Z pins from matching any command.
   always_comb begin
      is_lmr  = (cmd === 4'b0000);
      is_ref  = (cmd === 4'b0001);
      is_pre  = (cmd === 4'b0010);
      is_act  = (cmd === 4'b0011);
      is_wr   = (cmd === 4'b0100);
      is_rd   = (cmd === 4'b0101);
      is_bst  = (cmd === 4'b0110);
      a10     = (sdr_addr[10] === 1'b1);
      init_ok = (sdr_init_done === 1'b1);
      for (int i = 0; i < 4; i++) begin
         act_t[i] = is_act && (sdr_ba === 2'(i));
         rd_t[i]  = is_rd  && (sdr_ba === 2'(i));
         wr_t[i]  = is_wr  && (sdr_ba === 2'(i));
         ref_t[i] = is_ref && (sdr_ba === 2'(i));
         lmr_t[i] = is_lmr && (sdr_ba === 2'(i));
         bst_t[i] = is_bst && (sdr_ba === 2'(i));
         pre_t[i] = is_pre && (a10 || (sdr_ba === 2'(i)));
         any_t[i] = act_t[i] | rd_t[i] | wr_t[i] | ref_t[i] | lmr_t[i] | bst_t[i] | pre_t[i];
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      since_d    = since_q;
      cmd_err_d  = '0;
      tras_err_d = '0;
      trcd_err_d = '0;
      for (int i = 0; i < 4; i++) begin
         case (state_q[i])
            S_INIT: begin
               if (init_ok) state_d[i] = S_IDLE;
            end
            S_IDLE: begin
               if (act_t[i])      state_d[i] = S_ACTG;
               else if (ref_t[i]) state_d[i] = S_REF;
               cmd_err_d[i] = rd_t[i] | wr_t[i] | bst_t[i];
            end
            S_REF: begin
               state_d[i]   = S_IDLE;
               cmd_err_d[i] = any_t[i];
            end
            S_ACTG: begin
               if (cnt_q[i] >= TRCD_M1) state_d[i] = S_ACT;
               cmd_err_d[i] = any_t[i];
            end
            S_ACT: begin
               if (wr_t[i])       state_d[i] = a10 ? S_WRPC : S_WR;
               else if (rd_t[i])  state_d[i] = a10 ? S_RDPC : S_RD;
               else if (pre_t[i]) state_d[i] = S_PRE;
               cmd_err_d[i] = act_t[i] | ref_t[i] | lmr_t[i] | bst_t[i];
            end
            S_RD, S_WR: begin
               if (wr_t[i])                 state_d[i] = S_WR;
               else if (rd_t[i])            state_d[i] = S_RD;
               else if (pre_t[i])           state_d[i] = S_PRE;
               else if (bst_t[i])           state_d[i] = S_ACT;
               else if (cnt_q[i] >= BL_M1)  state_d[i] = S_ACT;
               cmd_err_d[i] = act_t[i] | ref_t[i] | lmr_t[i];
            end
            S_RDPC, S_WRPC: begin
               if (cnt_q[i] >= BL_M1) state_d[i] = S_PRE;
               cmd_err_d[i] = any_t[i];
            end
            S_PRE: begin
               if (cnt_q[i] >= TRP_M1) state_d[i] = S_IDLE;
               cmd_err_d[i] = any_t[i];
            end
            default: state_d[i] = S_INIT;
         endcase

         // A READ/WRITE landing in RD/WR restarts the burst count.
         if ((state_d[i] != state_q[i]) ||
             (((state_q[i] == S_RD) || (state_q[i] == S_WR)) && (rd_t[i] || wr_t[i])))
            cnt_d[i] = 8'd0;
         else if (cnt_q[i] != 8'hFF)
            cnt_d[i] = cnt_q[i] + 8'd1;

         if (act_t[i])
            since_d[i] = 8'd0;
         else if (since_q[i] != 8'hFF)
            since_d[i] = since_q[i] + 8'd1;

         tras_err_d[i] = pre_t[i] && (since_q[i] < TRAS_M1);
         trcd_err_d[i] = (rd_t[i] || wr_t[i]) && (since_q[i] < TRCD_M1);
      end
   end

   // Since-ACTIVE counters reset saturated so a fresh bank never flags timing.
   always_ff @(posedge sdram_clk or posedge sdram_reset) begin
      if (sdram_reset) begin
         state_q    <= '0;
         cnt_q      <= '0;
         since_q    <= '1;
         cmd_err_q  <= '0;
         tras_err_q <= '0;
         trcd_err_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         since_q    <= since_d;
         cmd_err_q  <= cmd_err_d;
         tras_err_q <= tras_err_d;
         trcd_err_q <= trcd_err_d;
      end
   end

   assign bank_state = state_q;
   assign cmd_err    = cmd_err_q;
   assign tras_err   = tras_err_q;
   assign trcd_err   = trcd_err_q;

endmodule

// File: tb/tb_sdr_modport.sv
// Directed bench for sdr_modport: bank FSM walk, tRCD/tRAS windows, burst with
// auto-precharge, DQ tristate and asynchronous reset.
module tb_sdr_modport;

   localparam logic [3:0] C_PRE = 4'b0010;
   localparam logic [3:0] C_ACT = 4'b0011;
   localparam logic [3:0] C_RD  = 4'b0101;
   localparam logic [3:0] C_NOP = 4'b0111;

   logic        sdram_clk = 1'b0;
   logic        sdram_reset;
   logic        sdr_init_done;
   logic        sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n;
   logic [1:0]  sdr_ba;
   logic [12:0] sdr_addr;
   logic [15:0] sdr_dout;
   logic [1:0]  sdr_den_n;
   wire  [15:0] sdr_dq;
   logic [15:0] sdr_din;
   logic [15:0] bank_state;
   logic [3:0]  cmd_err, tras_err, trcd_err;
   logic [15:0] tb_dq_drv;
   logic        tb_dq_en;

   int errors = 0;
   int checks = 0;

   assign sdr_dq = tb_dq_en ? tb_dq_drv : 16'hzzzz;

   always #5 sdram_clk = ~sdram_clk;

   sdr_modport #(
      .SDR_DW(16), .SDR_BW(2), .BURST_LENGTH(4), .TRAS(6),
      .TCAS(2), .TRCD(3), .TRP(2)
   ) dut (
      .sdram_clk(sdram_clk), .sdram_reset(sdram_reset), .sdr_init_done(sdr_init_done),
      .sdr_cs_n(sdr_cs_n), .sdr_ras_n(sdr_ras_n), .sdr_cas_n(sdr_cas_n), .sdr_we_n(sdr_we_n),
      .sdr_ba(sdr_ba), .sdr_addr(sdr_addr), .sdr_dout(sdr_dout), .sdr_den_n(sdr_den_n),
      .sdr_dq(sdr_dq), .sdr_din(sdr_din), .bank_state(bank_state),
      .cmd_err(cmd_err), .tras_err(tras_err), .trcd_err(trcd_err)
   );

   task automatic tick();
      @(posedge sdram_clk);
      #1;
   endtask

   task automatic drive_cmd(input logic [3:0] c, input logic [1:0] ba, input logic a10);
      {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = c;
      sdr_ba       = ba;
      sdr_addr     = 13'h0000;
      sdr_addr[10] = a10;
   endtask

   task automatic test_reset();
      sdram_reset = 1'b1;
      tick();
      tick();
      checks++;
      if (bank_state !== 16'h0000) begin errors++; $display("[TB] FAIL reset_state got %h want %h", bank_state, 16'h0000); end
      checks++;
      if ({cmd_err, tras_err, trcd_err} !== 12'h000) begin errors++; $display("[TB] FAIL reset_flags got %h want %h", {cmd_err, tras_err, trcd_err}, 12'h000); end
      sdram_reset = 1'b0;
      tick();
      checks++;
      if (bank_state !== 16'h0000) begin errors++; $display("[TB] FAIL init_hold got %h want %h", bank_state, 16'h0000); end
      sdr_init_done = 1'b1;
      tick();
      checks++;
      if (bank_state !== 16'h1111) begin errors++; $display("[TB] FAIL init_done got %h want %h", bank_state, 16'h1111); end
   endtask

   // ACTIVATING holds three cycles with TRCD=3, then ACTIVE.
   task automatic test_activate_delay();
      logic [15:0] exp_state [4];
      exp_state = '{16'h1131, 16'h1131, 16'h1131, 16'h1141};
      drive_cmd(C_ACT, 2'd1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         tick();
         drive_cmd(C_NOP, 2'd0, 1'b0);
         checks++;
         if (bank_state !== exp_state[k]) begin errors++; $display("[TB] FAIL act_delay_%0d got %h want %h", k, bank_state, exp_state[k]); end
      end
      checks++;
      if (cmd_err !== 4'b0000) begin errors++; $display("[TB] FAIL act_cmd_err got %b want %b", cmd_err, 4'b0000); end
   endtask

   task automatic test_trcd_violation();
      drive_cmd(C_ACT, 2'd2, 1'b0);
      tick();
      checks++;
      if (bank_state !== 16'h1341) begin errors++; $display("[TB] FAIL trcd_act got %h want %h", bank_state, 16'h1341); end
      drive_cmd(C_NOP, 2'd0, 1'b0);
      tick();
      drive_cmd(C_RD, 2'd2, 1'b0);
      tick();
      checks++;
      if (trcd_err !== 4'b0100) begin errors++; $display("[TB] FAIL trcd_off2 got %b want %b", trcd_err, 4'b0100); end
      checks++;
      if (cmd_err !== 4'b0100) begin errors++; $display("[TB] FAIL trcd_cmd_off2 got %b want %b", cmd_err, 4'b0100); end
      tick();
      checks++;
      if (trcd_err !== 4'b0000) begin errors++; $display("[TB] FAIL trcd_off3 got %b want %b", trcd_err, 4'b0000); end
      checks++;
      if (bank_state !== 16'h1441) begin errors++; $display("[TB] FAIL trcd_state got %h want %h", bank_state, 16'h1441); end
      drive_cmd(C_NOP, 2'd0, 1'b0);
      tick();
      tick();
   endtask

   // Precharge-all at offset 4 (< TRAS=6) hits bank 0 only; every active bank precharges.
   task automatic test_tras_precharge_all();
      drive_cmd(C_ACT, 2'd0, 1'b0);
      tick();
      drive_cmd(C_NOP, 2'd0, 1'b0);
      tick();
      tick();
      tick();
      checks++;
      if (bank_state !== 16'h1444) begin errors++; $display("[TB] FAIL tras_active got %h want %h", bank_state, 16'h1444); end
      drive_cmd(C_PRE, 2'd3, 1'b1);
      tick();
      drive_cmd(C_NOP, 2'd0, 1'b0);
      checks++;
      if (tras_err !== 4'b0001) begin errors++; $display("[TB] FAIL tras_err got %b want %b", tras_err, 4'b0001); end
      checks++;
      if (cmd_err !== 4'b0000) begin errors++; $display("[TB] FAIL tras_cmd_err got %b want %b", cmd_err, 4'b0000); end
      checks++;
      if (bank_state !== 16'h1999) begin errors++; $display("[TB] FAIL pre_all_1 got %h want %h", bank_state, 16'h1999); end
      tick();
      checks++;
      if (bank_state !== 16'h1999) begin errors++; $display("[TB] FAIL pre_all_2 got %h want %h", bank_state, 16'h1999); end
      checks++;
      if (tras_err !== 4'b0000) begin errors++; $display("[TB] FAIL tras_pulse got %b want %b", tras_err, 4'b0000); end
      tick();
      checks++;
      if (bank_state !== 16'h1111) begin errors++; $display("[TB] FAIL pre_all_idle got %h want %h", bank_state, 16'h1111); end
   endtask

   task automatic test_burst_autoprecharge();
      logic [15:0] exp_state [5];
      drive_cmd(C_ACT, 2'd3, 1'b0);
      tick();
      drive_cmd(C_NOP, 2'd0, 1'b0);
      tick();
      tick();
      tick();
      checks++;
      if (bank_state !== 16'h4111) begin errors++; $display("[TB] FAIL burst_active got %h want %h", bank_state, 16'h4111); end
      drive_cmd(C_RD, 2'd3, 1'b1);
      tick();
      checks++;
      if (bank_state !== 16'h6111) begin errors++; $display("[TB] FAIL burst_rdpc got %h want %h", bank_state, 16'h6111); end
      checks++;
      if ({cmd_err, trcd_err} !== 8'h00) begin errors++; $display("[TB] FAIL burst_rd_ok got %h want %h", {cmd_err, trcd_err}, 8'h00); end
      drive_cmd(C_RD, 2'd3, 1'b0);
      tick();
      drive_cmd(C_NOP, 2'd0, 1'b0);
      checks++;
      if (cmd_err !== 4'b1000) begin errors++; $display("[TB] FAIL burst_rd_illegal got %b want %b", cmd_err, 4'b1000); end
      exp_state = '{16'h6111, 16'h6111, 16'h9111, 16'h9111, 16'h1111};
      checks++;
      if (bank_state !== 16'h6111) begin errors++; $display("[TB] FAIL burst_hold got %h want %h", bank_state, 16'h6111); end
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if (bank_state !== exp_state[k]) begin errors++; $display("[TB] FAIL burst_seq_%0d got %h want %h", k, bank_state, exp_state[k]); end
      end
      checks++;
      if (cmd_err !== 4'b0000) begin errors++; $display("[TB] FAIL burst_cmd_clear got %b want %b", cmd_err, 4'b0000); end
   endtask

   task automatic test_tristate();
      sdr_den_n = 2'b11;
      sdr_dout  = 16'hFFFF;
      tb_dq_drv = 16'hA5A5;
      tb_dq_en  = 1'b1;
      #1;
      checks++;
      if (sdr_din !== 16'hA5A5) begin errors++; $display("[TB] FAIL tri_ext_a5 got %h want %h", sdr_din, 16'hA5A5); end
      tb_dq_drv = 16'h5A5A;
      #1;
      checks++;
      if (sdr_din !== 16'h5A5A) begin errors++; $display("[TB] FAIL tri_ext_5a got %h want %h", sdr_din, 16'h5A5A); end
      tb_dq_en  = 1'b0;
      sdr_den_n = 2'b10;
      sdr_dout  = 16'h1234;
      #1;
      checks++;
      if (sdr_dq !== 16'h1234) begin errors++; $display("[TB] FAIL tri_drive_dq got %h want %h", sdr_dq, 16'h1234); end
      checks++;
      if (sdr_din !== 16'h1234) begin errors++; $display("[TB] FAIL tri_drive_din got %h want %h", sdr_din, 16'h1234); end
      sdr_den_n = 2'b01;
      sdr_dout  = 16'hBEEF;
      #1;
      checks++;
      if (sdr_din !== 16'hBEEF) begin errors++; $display("[TB] FAIL tri_drive_hi got %h want %h", sdr_din, 16'hBEEF); end
      sdr_den_n = 2'b11;
   endtask

   task automatic test_reset_mid_burst();
      drive_cmd(C_ACT, 2'd0, 1'b0);
      tick();
      drive_cmd(C_NOP, 2'd0, 1'b0);
      tick();
      tick();
      tick();
      drive_cmd(C_RD, 2'd0, 1'b0);
      tick();
      checks++;
      if (bank_state !== 16'h1115) begin errors++; $display("[TB] FAIL mid_rd got %h want %h", bank_state, 16'h1115); end
      drive_cmd(C_ACT, 2'd0, 1'b0);
      tick();
      drive_cmd(C_NOP, 2'd0, 1'b0);
      checks++;
      if (cmd_err !== 4'b0001) begin errors++; $display("[TB] FAIL mid_act_illegal got %b want %b", cmd_err, 4'b0001); end
      sdram_reset = 1'b1;
      #1;
      checks++;
      if (bank_state !== 16'h0000) begin errors++; $display("[TB] FAIL mid_reset_async got %h want %h", bank_state, 16'h0000); end
      tick();
      checks++;
      if ({bank_state, cmd_err, tras_err, trcd_err} !== 28'h0) begin errors++; $display("[TB] FAIL mid_reset_edge got %h want %h", {bank_state, cmd_err, tras_err, trcd_err}, 28'h0); end
      sdram_reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      sdram_reset   = 1'b1;
      sdr_init_done = 1'b0;
      sdr_dout      = 16'h0000;
      sdr_den_n     = 2'b11;
      tb_dq_drv     = 16'h0000;
      tb_dq_en      = 1'b0;
      drive_cmd(C_NOP, 2'd0, 1'b0);
      test_reset();
      test_activate_delay();
      test_trcd_violation();
      test_tras_precharge_all();
      test_burst_autoprecharge();
      test_tristate();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
